ntt_radix_out_fifo: RTL and testbench

NTT_RADIX_OUT_FIFO -- requirements
Module: ntt_radix_out_fifo

---
 rtl/ntt_radix_out_fifo.sv | 90 +++++++++
 tb/tb_ntt_radix_out_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ntt_radix_out_fifo.sv
// Output buffer behind the NTT radix stage: one R-coefficient word plus side data per slot.
// Words become visible one cycle after the push. When full with no pop, an incoming word is dropped and a sticky overflow flag is set.
module ntt_radix_out_fifo #(
    parameter int R         = 8,
    parameter int OP_W      = 64,
    parameter int SIDE_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 4
) (
    input  logic                                   clk,
    input  logic                                   a_rst_n,
    input  logic                                   in_avail,
    input  logic [R-1:0][OP_W-1:0]                 in_data,
    input  logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] in_side,
    output logic                                   out_vld,
    input  logic                                   out_rdy,
    output logic [R-1:0][OP_W-1:0]                 out_data,
    output logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] out_side,
    output logic                                   almost_full,
    output logic [$clog2(DEPTH):0]                 count,
    output logic                                   overflow
);

    localparam int DW = R * OP_W;
    // With SIDE_W=0 the one-bit side path is still carried through; it has no meaning.
    localparam int SW = (SIDE_W > 0) ? SIDE_W : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);

    logic [DW+SW-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_af;
    logic             r_ovf;

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [CW-1:0]    w_count_next;
    logic [DW+SW-1:0] w_head;

    assign w_full = (r_count == FULL_LVL);
    assign w_pop  = (r_count != '0) && out_rdy;
    // A word arriving while full is still accepted when the head leaves in the same cycle.
    assign w_push = in_avail && (!w_full || w_pop);
    assign w_drop = in_avail && w_full && !w_pop;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_af    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_next;
            r_af    <= (w_count_next >= AF_LVL);
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {in_data, in_side};
    end

    assign w_head      = r_mem[r_rptr];
    assign out_data    = w_head[DW+SW-1:SW];
    assign out_side    = w_head[SW-1:0];
    assign out_vld     = (r_count != '0);
    assign count       = r_count;
    assign almost_full = r_af;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_ntt_radix_out_fifo.sv
// Directed and random checks of ntt_radix_out_fifo against a queue model of the buffer.
module tb_ntt_radix_out_fifo;

    localparam int R         = 4;
    localparam int OP_W      = 16;
    localparam int SIDE_W    = 8;
    localparam int DEPTH     = 8;
    localparam int AF_MARGIN = 4;
    localparam int DW        = R * OP_W;
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int W         = DW + SIDE_W;

    logic                   clk;
    logic                   a_rst_n;
    logic                   in_avail;
    logic [R-1:0][OP_W-1:0] in_data;
    logic [SIDE_W-1:0]      in_side;
    logic                   out_vld;
    logic                   out_rdy;
    logic [R-1:0][OP_W-1:0] out_data;
    logic [SIDE_W-1:0]      out_side;
    logic                   almost_full;
    logic [CW-1:0]          count;
    logic                   overflow;

    ntt_radix_out_fifo #(
        .R(R), .OP_W(OP_W), .SIDE_W(SIDE_W), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)
    ) dut (
        .clk(clk), .a_rst_n(a_rst_n), .in_avail(in_avail), .in_data(in_data),
        .in_side(in_side), .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_side(out_side), .almost_full(almost_full), .count(count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic         m_ovf = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_word(input int k);
        logic [DW-1:0] w;
        for (int i = 0; i < R; i++) w[i*OP_W +: OP_W] = OP_W'(k * 16 + i) ^ 16'h5A00;
        return w;
    endfunction

    function automatic logic [SIDE_W-1:0] mk_side(input int k);
        return SIDE_W'(k * 7 + 3);
    endfunction

    // Called at posedge+1: drives one cycle of inputs, checks the head, then checks state after the edge.
    task automatic step(input logic avail, input logic [DW-1:0] d, input logic [SIDE_W-1:0] s,
                        input logic rdy);
        logic pop;
        logic push;
        in_avail = avail;
        in_data  = d;
        in_side  = s;
        out_rdy  = rdy;
        pop  = (exp_q.size() > 0) && rdy;
        push = avail && ((exp_q.size() < DEPTH) || pop);
        if (exp_q.size() > 0) begin
            check("head_data", 128'(out_data), 128'(exp_q[0][W-1:SIDE_W]));
            check("head_side", 128'(out_side), 128'(exp_q[0][SIDE_W-1:0]));
        end
        if (avail && !push) m_ovf = 1'b1;
        @(posedge clk);
        #1;
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back({d, s});
        check("out_vld", 128'(out_vld), 128'(exp_q.size() > 0));
        check("count", 128'(count), 128'(exp_q.size()));
        check("almost_full", 128'(almost_full), 128'(exp_q.size() >= DEPTH - AF_MARGIN));
        check("overflow", 128'(overflow), 128'(m_ovf));
    endtask

    task automatic push_word(input int k, input logic rdy);
        step(1'b1, mk_word(k), mk_side(k), rdy);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, '0, rdy);
    endtask

    initial begin
        int pushed;
        int guard;
        logic av;
        a_rst_n  = 1'b0;
        in_avail = 1'b0;
        in_data  = '0;
        in_side  = '0;
        out_rdy  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", 128'(out_vld), 128'(0));
        check("rst_count", 128'(count), 128'(0));
        check("rst_af", 128'(almost_full), 128'(0));
        check("rst_ovf", 128'(overflow), 128'(0));
        a_rst_n = 1'b1;

        // In-order streaming with the consumer always ready
        for (int k = 0; k < 20; k++) begin
            push_word(k, 1'b1);
            check("inorder_cnt_le1", 128'(count <= 1), 128'(1));
        end
        idle(1'b1);
        check("inorder_empty", 128'(out_vld), 128'(0));
        check("inorder_ovf", 128'(overflow), 128'(0));

        // Fill then drain
        for (int i = 0; i < 8; i++) begin
            push_word(100 + i, 1'b0);
            if (i == 2) check("af_after3", 128'(almost_full), 128'(0));
            if (i == 3) check("af_after4", 128'(almost_full), 128'(1));
        end
        check("fill_count", 128'(count), 128'(8));
        for (int i = 0; i < 8; i++) idle(1'b1);
        check("drain_count", 128'(count), 128'(0));
        check("drain_vld", 128'(out_vld), 128'(0));

        // Push and pop together while full
        for (int i = 0; i < 8; i++) push_word(200 + i, 1'b0);
        push_word(208, 1'b1);
        check("pp_count", 128'(count), 128'(8));
        check("pp_ovf", 128'(overflow), 128'(0));
        check("pp_head", 128'(out_data), 128'(mk_word(201)));
        for (int i = 0; i < 8; i++) idle(1'b1);
        check("pp_drain_count", 128'(count), 128'(0));

        // Overflow: word dropped, flag sticky, contents intact
        for (int i = 0; i < 8; i++) push_word(300 + i, 1'b0);
        push_word(309, 1'b0);
        check("ovf_set", 128'(overflow), 128'(1));
        check("ovf_count", 128'(count), 128'(8));
        check("ovf_head", 128'(out_data), 128'(mk_word(300)));
        idle(1'b0);
        check("ovf_sticky", 128'(overflow), 128'(1));
        for (int i = 0; i < 8; i++) idle(1'b1);
        check("ovf_drain_vld", 128'(out_vld), 128'(0));
        check("ovf_still_set", 128'(overflow), 128'(1));

        // Reset mid-stream, with in_avail held high during reset
        for (int i = 0; i < 5; i++) push_word(400 + i, 1'b0);
        #2;
        a_rst_n  = 1'b0;
        in_avail = 1'b1;
        in_data  = mk_word(499);
        in_side  = mk_side(499);
        #1;
        check("mrst_vld", 128'(out_vld), 128'(0));
        check("mrst_count", 128'(count), 128'(0));
        check("mrst_ovf", 128'(overflow), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        check("mrst_hold_count", 128'(count), 128'(0));
        check("mrst_hold_vld", 128'(out_vld), 128'(0));
        a_rst_n = 1'b1;
        exp_q.delete();
        m_ovf = 1'b0;
        push_word(410, 1'b0);
        check("mrst_first_data", 128'(out_data), 128'(mk_word(410)));
        check("mrst_first_side", 128'(out_side), 128'(mk_side(410)));
        check("mrst_first_count", 128'(count), 128'(1));
        idle(1'b1);

        // Random soak, producer throttled by almost_full
        pushed = 0;
        while (pushed < 50000) begin
            av = ($urandom_range(0, 99) < 95) && !almost_full;
            step(av, {$urandom, $urandom}, SIDE_W'($urandom), $urandom_range(0, 99) < 90);
            if (av) pushed++;
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 4 * DEPTH) begin
            idle(1'b1);
            guard++;
        end
        check("soak_drained", 128'(count), 128'(0));
        check("soak_ovf", 128'(overflow), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
